// File: rtl/pipeline_ex_mem_skid.sv
// EX/MEM pipeline register with a two-entry skid buffer: one-cycle latency,
// full throughput, and a ready_o that is decoded from registered state only.
module pipeline_ex_mem_skid #(
   parameter int DATA_W = 32,
   parameter int REG_W  = 5,
   parameter int WB_W   = 2
) (
   input  logic              clk_i,
   input  logic              rst_n_i,
   input  logic              flush_i,
   input  logic              valid_i,
   output logic              ready_o,
   input  logic [WB_W-1:0]   WB_i,
   input  logic [1:0]        M_i,
   input  logic [DATA_W-1:0] ALU_data_i,
   input  logic [DATA_W-1:0] ALUSrc_data_i,
   input  logic [REG_W-1:0]  RegDst_i,
   output logic              valid_o,
   input  logic              ready_i,
   output logic [WB_W-1:0]   WB_o,
   output logic              MemRead_o,
   output logic              MemWrite_o,
   output logic [DATA_W-1:0] addr_o,
   output logic [DATA_W-1:0] write_data_o,
   output logic [REG_W-1:0]  RegDst_o,
   output logic              fwd_valid_o,
   output logic [REG_W-1:0]  fwd_reg_o,
   output logic [DATA_W-1:0] fwd_data_o
);

   typedef enum logic [1:0] {
      EMPTY = 2'd0,
      ONE   = 2'd1,
      TWO   = 2'd2
   } state_t;

   typedef struct packed {
      logic [WB_W-1:0]   wb;
      logic [1:0]        m;
      logic [DATA_W-1:0] alu;
      logic [DATA_W-1:0] store;
      logic [REG_W-1:0]  rd;
   } entry_t;

   state_t state, state_nxt;
   entry_t main_q, skid_q, in_entry;
   logic   accept, drain;
   logic   load_main, load_skid, skid_to_main;

   assign in_entry = '{wb: WB_i, m: M_i, alu: ALU_data_i, store: ALUSrc_data_i, rd: RegDst_i};

   assign ready_o = (state != TWO);
   assign valid_o = (state != EMPTY);
   assign accept  = valid_i & ready_o;
   assign drain   = valid_o & ready_i;

   always_ff @(posedge clk_i or negedge rst_n_i) begin
      if (!rst_n_i) begin
         state <= EMPTY;
      end else begin
         state <= state_nxt;
      end
   end

   // NOTE: every signal driven here gets a default first, so no path leaves one unassigned (no latch).
   always_comb begin
      state_nxt    = state;
      load_main    = 1'b0;
      load_skid    = 1'b0;
      skid_to_main = 1'b0;
      if (flush_i) begin
         state_nxt = EMPTY;
      end else begin
         case (state)
            EMPTY: begin
               if (accept) begin
                  load_main = 1'b1;
                  state_nxt = ONE;
               end
            end
            ONE: begin
               if (accept && drain) begin
                  load_main = 1'b1;
               end else if (accept) begin
                  load_skid = 1'b1;
                  state_nxt = TWO;
               end else if (drain) begin
                  state_nxt = EMPTY;
               end
            end
            TWO: begin
               if (drain) begin
                  skid_to_main = 1'b1;
                  state_nxt    = ONE;
               end
            end
            default: state_nxt = EMPTY;
         endcase
      end
   end

   // NOTE: the entry registers are reset too, so outputs read as zero while held in reset.
   always_ff @(posedge clk_i or negedge rst_n_i) begin
      if (!rst_n_i) begin
         main_q <= '0;
         skid_q <= '0;
      end else begin
         if (load_main) begin
            main_q <= in_entry;
         end else if (skid_to_main) begin
            main_q <= skid_q;
         end
         if (load_skid) begin
            skid_q <= in_entry;
         end
      end
   end

   // Control strobes are masked when empty; datapath fields keep their last value.
   assign WB_o         = valid_o ? main_q.wb : '0;
   assign MemRead_o    = valid_o & main_q.m[1];
   assign MemWrite_o   = valid_o & main_q.m[0];
   assign addr_o       = main_q.alu;
   assign write_data_o = main_q.store;
   assign RegDst_o     = main_q.rd;

   assign fwd_valid_o  = valid_o & (|WB_o);
   assign fwd_reg_o    = main_q.rd;
   assign fwd_data_o   = main_q.alu;

endmodule

// File: tb/tb_pipeline_ex_mem_skid.sv
// Directed self-checking bench for pipeline_ex_mem_skid with hand-computed expectations.
module tb_pipeline_ex_mem_skid;

   localparam int DATA_W = 32;
   localparam int REG_W  = 5;
   localparam int WB_W   = 2;

   logic              clk = 1'b0;
   logic              rst_n;
   logic              flush;
   logic              valid_in;
   logic              ready_out;
   logic [WB_W-1:0]   wb_in;
   logic [1:0]        m_in;
   logic [DATA_W-1:0] alu_in;
   logic [DATA_W-1:0] store_in;
   logic [REG_W-1:0]  rd_in;
   logic              valid_out;
   logic              ready_in;
   logic [WB_W-1:0]   wb_out;
   logic              mem_read;
   logic              mem_write;
   logic [DATA_W-1:0] addr;
   logic [DATA_W-1:0] write_data;
   logic [REG_W-1:0]  rd_out;
   logic              fwd_valid;
   logic [REG_W-1:0]  fwd_reg;
   logic [DATA_W-1:0] fwd_data;

   int errors = 0;
   int checks = 0;

   pipeline_ex_mem_skid #(.DATA_W(DATA_W), .REG_W(REG_W), .WB_W(WB_W)) dut (
      .clk_i        (clk),
      .rst_n_i      (rst_n),
      .flush_i      (flush),
      .valid_i      (valid_in),
      .ready_o      (ready_out),
      .WB_i         (wb_in),
      .M_i          (m_in),
      .ALU_data_i   (alu_in),
      .ALUSrc_data_i(store_in),
      .RegDst_i     (rd_in),
      .valid_o      (valid_out),
      .ready_i      (ready_in),
      .WB_o         (wb_out),
      .MemRead_o    (mem_read),
      .MemWrite_o   (mem_write),
      .addr_o       (addr),
      .write_data_o (write_data),
      .RegDst_o     (rd_out),
      .fwd_valid_o  (fwd_valid),
      .fwd_reg_o    (fwd_reg),
      .fwd_data_o   (fwd_data)
   );

   always #5 clk = ~clk;

   task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
      checks++;
      if (got !== exp) begin
         errors++;
         $display("FAIL %s: got 0x%0h, expected 0x%0h", tag, got, exp);
      end
   endtask

   // Advance past one rising edge; checks then run 1 time unit after it.
   task automatic step();
      @(posedge clk);
      #1;
   endtask

   task automatic drive(input logic v, input logic [WB_W-1:0] wb, input logic [1:0] m,
                        input logic [DATA_W-1:0] alu, input logic [REG_W-1:0] rd);
      valid_in = v;
      wb_in    = wb;
      m_in     = m;
      alu_in   = alu;
      store_in = alu + 32'h1000;
      rd_in    = rd;
   endtask

   initial begin
      rst_n    = 1'b0;
      flush    = 1'b0;
      ready_in = 1'b0;
      drive(1'b0, '0, '0, '0, '0);
      #1;
      check("rst_valid", valid_out, 1'b0);
      check("rst_ready", ready_out, 1'b1);
      check("rst_addr", addr, 32'h0);
      step();
      step();
      #3 rst_n = 1'b1;

      // Single read entry, one-cycle latency.
      drive(1'b1, 2'b01, 2'b10, 32'h10, 5'd3);
      ready_in = 1'b1;
      step();
      check("rd_valid", valid_out, 1'b1);
      check("rd_addr", addr, 32'h10);
      check("rd_memread", mem_read, 1'b1);
      check("rd_memwrite", mem_write, 1'b0);
      check("rd_wdata", write_data, 32'h1010);
      drive(1'b0, '0, '0, '0, '0);
      step();
      check("drained_valid", valid_out, 1'b0);
      check("drained_memread_mask", mem_read, 1'b0);
      check("drained_wb_mask", wb_out, 2'b00);
      check("drained_addr_hold", addr, 32'h10);

      // A, B, C with a stalled consumer.
      ready_in = 1'b0;
      drive(1'b1, 2'b01, 2'b00, 32'h1, 5'd1);
      step();
      check("A_out", addr, 32'h1);
      check("A_ready", ready_out, 1'b1);
      drive(1'b1, 2'b01, 2'b00, 32'h2, 5'd2);
      step();
      check("B_skid_addr", addr, 32'h1);
      check("B_skid_ready", ready_out, 1'b0);
      drive(1'b1, 2'b01, 2'b00, 32'h3, 5'd3);
      step();
      check("C_held_addr", addr, 32'h1);
      check("C_held_rd", rd_out, 5'd1);
      check("C_held_ready", ready_out, 1'b0);
      ready_in = 1'b1;
      step();
      check("drain_B", addr, 32'h2);
      check("drain_B_ready", ready_out, 1'b1);
      step();
      check("drain_C", addr, 32'h3);
      drive(1'b0, '0, '0, '0, '0);
      step();
      check("abc_empty", valid_out, 1'b0);

      // Eight back-to-back entries at full throughput.
      for (int i = 0; i < 8; i++) begin
         drive(1'b1, 2'b11, 2'b00, 32'h100 + i, 5'(i));
         step();
         check("stream_addr", addr, 32'h100 + i);
         check("stream_valid", valid_out, 1'b1);
         check("stream_ready", ready_out, 1'b1);
      end
      drive(1'b0, '0, '0, '0, '0);
      step();
      check("stream_empty", valid_out, 1'b0);

      // Forwarding tap.
      ready_in = 1'b0;
      drive(1'b1, 2'b10, 2'b00, 32'h55, 5'd7);
      step();
      check("fwd_valid", fwd_valid, 1'b1);
      check("fwd_reg", fwd_reg, 5'd7);
      check("fwd_data", fwd_data, 32'h55);
      ready_in = 1'b1;
      drive(1'b1, 2'b00, 2'b00, 32'h66, 5'd9);
      step();
      check("fwd_nowb_valid", fwd_valid, 1'b0);
      check("fwd_nowb_reg", fwd_reg, 5'd9);
      drive(1'b0, '0, '0, '0, '0);
      step();

      // Flush while holding two store entries.
      ready_in = 1'b0;
      drive(1'b1, 2'b01, 2'b01, 32'h70, 5'd4);
      step();
      check("st_memwrite", mem_write, 1'b1);
      check("st_memread", mem_read, 1'b0);
      drive(1'b1, 2'b01, 2'b01, 32'h71, 5'd5);
      step();
      check("st_two_ready", ready_out, 1'b0);
      flush = 1'b1;
      #1;
      check("flush_cycle_ready", ready_out, 1'b0);
      step();
      check("flush_valid", valid_out, 1'b0);
      check("flush_memwrite", mem_write, 1'b0);
      check("flush_wb", wb_out, 2'b00);
      check("flush_ready", ready_out, 1'b1);
      drive(1'b1, 2'b01, 2'b01, 32'h80, 5'd6);
      step();
      check("flush_beats_accept", valid_out, 1'b0);
      flush = 1'b0;
      drive(1'b0, '0, '0, '0, '0);

      // Asynchronous reset pulse between edges while holding one entry.
      drive(1'b1, 2'b01, 2'b10, 32'h90, 5'd8);
      step();
      drive(1'b0, '0, '0, '0, '0);
      check("pre_rst_valid", valid_out, 1'b1);
      #2 rst_n = 1'b0;
      #1;
      check("async_rst_valid", valid_out, 1'b0);
      check("async_rst_addr", addr, 32'h0);
      check("async_rst_ready", ready_out, 1'b1);
      #1 rst_n = 1'b1;
      step();
      check("post_rst_empty", valid_out, 1'b0);

      // Reset still low at an edge blocks the accept; next edge accepts from EMPTY.
      rst_n    = 1'b0;
      ready_in = 1'b1;
      drive(1'b1, 2'b01, 2'b10, 32'hA0, 5'd10);
      step();
      check("rst_edge_no_accept", valid_out, 1'b0);
      #3 rst_n = 1'b1;
      step();
      check("after_rst_accept_valid", valid_out, 1'b1);
      check("after_rst_accept_addr", addr, 32'hA0);
      drive(1'b0, '0, '0, '0, '0);
      step();

      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end

endmodule

// File: doc/pipeline_ex_mem_skid.md
PIPELINE_EX_MEM_SKID -- requirements
Module: pipeline_ex_mem_skid

Interface
REQ-001 Parameter DATA_W, default 32, width of ALU result and store data.
REQ-002 Parameter REG_W, default 5, width of destination register index.
REQ-003 Parameter WB_W, default 2, width of write-back control field.
REQ-004 clk_i  input  1  single clock; all state changes on rising edge.
REQ-005 rst_n_i  input  1  reset, asynchronous assert, active-low.
REQ-006 flush_i  input  1  synchronous flush; discards all held and incoming entries.
REQ-007 valid_i  input  1  EX stage presents an entry.
REQ-008 ready_o  output  1  stage can accept an entry this cycle.
REQ-009 WB_i  input  WB_W  write-back control.
REQ-010 M_i  input  2  memory control: bit1 = read, bit0 = write.
REQ-011 ALU_data_i  input  DATA_W  ALU result, used as memory address.
REQ-012 ALUSrc_data_i  input  DATA_W  store data.
REQ-013 RegDst_i  input  REG_W  destination register.
REQ-014 valid_o  output  1  MEM stage entry valid.
REQ-015 ready_i  input  1  MEM stage accepts the entry this cycle.
REQ-016 WB_o  output  WB_W  write-back control, masked.
REQ-017 MemRead_o, MemWrite_o  output  1 each  memory strobes, masked.
REQ-018 addr_o, write_data_o  output  DATA_W each  address and store data.
REQ-019 RegDst_o  output  REG_W  destination register.
REQ-020 fwd_valid_o, fwd_reg_o, fwd_data_o  output  1/REG_W/DATA_W  forwarding tap: output entry's valid AND WB_o nonzero, RegDst_o, addr_o.

Function
REQ-021 accept = valid_i & ready_o; drain = valid_o & ready_i.
REQ-022 The stage SHALL hold two entries: main (drives outputs) and skid; state EMPTY, ONE, TWO.
REQ-023 ready_o SHALL be 1 in EMPTY and ONE and 0 in TWO, decoded from registered state only, with no combinational path from ready_i.
REQ-024 EMPTY: accept -> load main, go ONE; else stay.
REQ-025 ONE: accept & drain -> load main, stay ONE; accept & !drain -> load skid, go TWO; !accept & drain -> go EMPTY; else stay.
REQ-026 TWO: drain -> main <= skid, go ONE; else stay. No accept is possible in TWO.
REQ-027 Latency SHALL be 1 cycle: an entry accepted at edge N appears on outputs after edge N when main is free or draining at N.
REQ-028 Entries SHALL leave in acceptance order; none dropped or duplicated absent flush.
REQ-029 While valid_o=1 and ready_i=0, all outputs SHALL hold stable.
REQ-030 valid_o SHALL be 1 exactly in ONE and TWO.
REQ-031 WB_o, MemRead_o, MemWrite_o SHALL be forced to 0 whenever valid_o=0; addr_o, write_data_o, RegDst_o hold last main value.
REQ-032 MemRead_o SHALL come from M_i[1] and MemWrite_o from M_i[0] of the stored entry; both set is passed through unchanged.
REQ-033 flush_i=1 at an edge SHALL take priority over accept and drain: state -> EMPTY, the incoming entry is discarded, valid_o=0 after that edge.
REQ-034 ready_o SHALL follow REQ-023 during a flush cycle; flush does not change input-side handshake semantics.

Reset
REQ-035 rst_n_i=0 SHALL immediately, without a clock edge, set state EMPTY, valid_o=0, ready_o=1, and every data/control register to 0.
REQ-036 Reset asserted mid-transfer SHALL discard both entries; first accept after release behaves as from EMPTY.
REQ-037 Reset release SHALL take effect at the next rising edge; no accept occurs on the release edge if rst_n_i is still low at that edge.

Verification
REQ-038 Reset then valid_i=1, ALU_data_i=0x10, M_i=2'b10, ready_i=1 -> next cycle valid_o=1, addr_o=0x10, MemRead_o=1, MemWrite_o=0.
REQ-039 Stream A=1, B=2, C=3 with ready_i=0 -> A on outputs, B in skid, ready_o=0 after B, C held; ready_i=1 -> outputs 1, 2, 3 in order, ready_o back to 1.
REQ-040 Continuous valid_i and ready_i=1 for 8 entries -> one entry per cycle, ready_o constantly 1, state stays ONE.
REQ-041 TWO state with M_i=2'b01 entries, flush_i=1 one cycle -> valid_o=0, MemWrite_o=0, WB_o=0 next cycle, ready_o=1.
REQ-042 rst_n_i pulsed low between edges while in ONE -> valid_o=0 and addr_o=0 before the next edge.
REQ-043 Entry WB_i=2'b10, RegDst_i=7, ALU_data_i=0x55 at output -> fwd_valid_o=1, fwd_reg_o=7, fwd_data_o=0x55; with WB_i=0 -> fwd_valid_o=0.
